guess_tracker: RTL and testbench

Downstream consumer of the keyboard letter decoder in the Hangman datapath. Turns the decoder's `pressed` level and 5-bit letter code into one-shot guess events. Scores each guess against a loaded secret word and tracks the used-letter set, the revealed positions, the wrong-guess count and the win/lose outcome. Its outputs drive the display and top-level game control.

---
 rtl/hangman_pkg.sv | 8 +
 rtl/letter_matcher.sv | 15 +
 rtl/guess_tracker.sv | 109 ++++++++++
 tb/tb_guess_tracker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// hangman_pkg: shared letter-code constants and guess FSM state encoding
package hangman_pkg;
    localparam int LETTER_W = 5;
    localparam int NUM_LETTERS = 26;
    localparam logic [LETTER_W-1:0] KEY_ENTER = 5'd26;
    localparam logic [LETTER_W-1:0] KEY_NONE = 5'd27;
    typedef enum logic [2:0] {IDLE, WAIT_PRESS, CHECK, WAIT_RELEASE, DONE} state_t;
endpackage

// File: rtl/letter_matcher.sv
// letter_matcher: per-position compare of a guessed letter against the active part of the word
module letter_matcher
    import hangman_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic [LETTER_W*MAX_LEN-1:0] word,
    input  logic [3:0]                  len,
    input  logic [LETTER_W-1:0]         letter,
    output logic [MAX_LEN-1:0]          match
);
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
        assign match[i] = (4'(i) < len) && (word[LETTER_W*i +: LETTER_W] == letter);
    end
endmodule

// File: rtl/guess_tracker.sv
// guess_tracker: turns key presses into one-shot guesses and scores them against the loaded word
module guess_tracker
    import hangman_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int MAX_WRONG = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pressed,
    input  logic [LETTER_W-1:0]            inputLetter,
    input  logic                           word_load,
    input  logic [LETTER_W*MAX_LEN-1:0]    word_letters,
    input  logic [3:0]                     word_len,
    output logic                           guess_strobe,
    output logic                           guess_hit,
    output logic                           enter_pulse,
    output logic [NUM_LETTERS-1:0]         used_mask,
    output logic [MAX_LEN-1:0]             reveal_mask,
    output logic [$clog2(MAX_WRONG+1)-1:0] wrong_count,
    output logic                           game_won,
    output logic                           game_lost
);
    localparam int WRONG_W = $clog2(MAX_WRONG + 1);
    state_t state;
    logic [LETTER_W*MAX_LEN-1:0] word_q;
    logic [3:0] len_q, len_c;
    logic [LETTER_W-1:0] letter_q;
    logic pressed_q, edge_c;
    logic [MAX_LEN-1:0] match, load_reveal, new_reveal;
    logic [WRONG_W-1:0] wrong_inc;
    letter_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
        .word   (word_q),
        .len    (len_q),
        .letter (letter_q),
        .match  (match)
    );
    assign edge_c = pressed & ~pressed_q;
    assign new_reveal = reveal_mask | match;
    assign wrong_inc = (wrong_count == WRONG_W'(MAX_WRONG)) ? wrong_count : wrong_count + 1'b1;
    always_comb begin
        len_c = (word_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : word_len;
        for (int i = 0; i < MAX_LEN; i++)
            load_reveal[i] = (4'(i) >= len_c) || (word_letters[LETTER_W*i +: LETTER_W] >= KEY_ENTER);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            word_q <= '0;
            len_q <= '0;
            letter_q <= '0;
            pressed_q <= 1'b0;
            guess_strobe <= 1'b0;
            guess_hit <= 1'b0;
            enter_pulse <= 1'b0;
            used_mask <= '0;
            reveal_mask <= '0;
            wrong_count <= '0;
            game_won <= 1'b0;
            game_lost <= 1'b0;
        end else begin
            pressed_q <= pressed;
            guess_strobe <= 1'b0;
            guess_hit <= 1'b0;
            enter_pulse <= 1'b0;
            if (word_load) begin
                used_mask <= '0;
                wrong_count <= '0;
                game_won <= 1'b0;
                game_lost <= 1'b0;
                if (word_len == 4'd0) begin
                    state <= IDLE;
                    word_q <= '0;
                    len_q <= '0;
                    reveal_mask <= '0;
                end else begin
                    state <= pressed ? WAIT_RELEASE : WAIT_PRESS;
                    word_q <= word_letters;
                    len_q <= len_c;
                    reveal_mask <= load_reveal;
                end
            end else begin
                case (state)
                    IDLE: enter_pulse <= edge_c && (inputLetter == KEY_ENTER);
                    WAIT_PRESS, DONE: if (edge_c) begin
                        letter_q <= inputLetter;
                        enter_pulse <= inputLetter == KEY_ENTER;
                        state <= (state == WAIT_PRESS && inputLetter < KEY_ENTER && !used_mask[inputLetter])
                                 ? CHECK : WAIT_RELEASE;
                    end
                    CHECK: begin
                        used_mask[letter_q] <= 1'b1;
                        reveal_mask <= new_reveal;
                        guess_strobe <= 1'b1;
                        guess_hit <= |match;
                        game_won <= &new_reveal;
                        if (~|match) begin
                            wrong_count <= wrong_inc;
                            game_lost <= wrong_inc == WRONG_W'(MAX_WRONG);
                        end
                        state <= WAIT_RELEASE;
                    end
                    WAIT_RELEASE: if (!pressed) state <= (game_won || game_lost) ? DONE : WAIT_PRESS;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_guess_tracker.sv
// tb_guess_tracker: scenario and randomized checks of guess_tracker against a set-based game model
module tb_guess_tracker;
    logic clk = 0, reset = 0, pressed = 0, word_load = 0;
    logic [4:0] inputLetter = 5'd27;
    logic [39:0] word_letters = '0;
    logic [3:0] word_len = '0;
    logic guess_strobe, guess_hit, enter_pulse, game_won, game_lost;
    logic [25:0] used_mask;
    logic [7:0] reveal_mask;
    logic [2:0] wrong_count;
    int checks = 0, errors = 0;
    bit m_active;
    int m_word[8];
    int m_len;
    bit [25:0] m_used;

    always #5 clk = ~clk;

    guess_tracker dut (
        .clk(clk), .reset(reset), .pressed(pressed), .inputLetter(inputLetter),
        .word_load(word_load), .word_letters(word_letters), .word_len(word_len),
        .guess_strobe(guess_strobe), .guess_hit(guess_hit), .enter_pulse(enter_pulse),
        .used_mask(used_mask), .reveal_mask(reveal_mask), .wrong_count(wrong_count),
        .game_won(game_won), .game_lost(game_lost)
    );

    function automatic bit in_word(int l);
        for (int i = 0; i < m_len; i++) if (m_word[i] == l) return 1;
        return 0;
    endfunction

    function automatic logic [7:0] m_reveal();
        logic [7:0] r = '0;
        if (!m_active) return r;
        for (int i = 0; i < 8; i++) r[i] = (i >= m_len) || (m_word[i] >= 26) || m_used[m_word[i]];
        return r;
    endfunction

    function automatic int m_wrong();
        int n = 0;
        for (int k = 0; k < 26; k++) if (m_used[k] && !in_word(k)) n++;
        return n;
    endfunction

    function automatic bit m_won();
        return m_active && (&m_reveal());
    endfunction

    function automatic bit m_lost();
        return m_wrong() >= 6;
    endfunction

    task automatic load(input int w[8], input int len, input bit hold);
        logic [39:0] wl;
        for (int i = 0; i < 8; i++) wl[5*i +: 5] = 5'(w[i]);
        @(negedge clk);
        word_load = 1; word_letters = wl; word_len = 4'(len);
        pressed = hold; inputLetter = hold ? 5'($urandom_range(0, 25)) : 5'd27;
        m_active = (len != 0); m_len = (len > 8) ? 8 : len; m_word = w; m_used = '0;
        @(negedge clk);
        word_load = 0;
        checks++;
        if (reveal_mask !== m_reveal()) begin errors++; $display("FAIL load_reveal got=%b exp=%b", reveal_mask, m_reveal()); end
        checks++;
        if (used_mask !== 26'd0 || wrong_count !== 3'd0 || game_won !== 1'b0 || game_lost !== 1'b0 || guess_strobe !== 1'b0)
            begin errors++; $display("FAIL load_clear used=%h wrong=%0d won=%b lost=%b strobe=%b exp all 0", used_mask, wrong_count, game_won, game_lost, guess_strobe); end
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (guess_strobe !== 1'b0 || used_mask !== 26'd0) begin errors++; $display("FAIL load_hold_noguess strobe=%b used=%h exp 0", guess_strobe, used_mask); end
            end
            pressed = 0;
        end
        @(negedge clk);
    endtask

    task automatic press(input logic [4:0] l, input int hold, output int strobes);
        bit exp_g, exp_h, exp_e;
        exp_g = m_active && !m_won() && !m_lost() && l < 26 && !m_used[l];
        exp_h = exp_g && in_word(int'(l));
        exp_e = (l == 5'd26);
        strobes = 0;
        @(negedge clk);
        pressed = 1; inputLetter = l;
        @(negedge clk);
        checks++;
        if (enter_pulse !== exp_e || guess_strobe !== 1'b0) begin errors++; $display("FAIL n1_pulses letter=%0d enter=%b strobe=%b exp enter=%b strobe=0", l, enter_pulse, guess_strobe, exp_e); end
        if (exp_g) m_used[l] = 1;
        @(negedge clk);
        strobes += int'(guess_strobe);
        checks++;
        if (guess_strobe !== exp_g || guess_hit !== exp_h || enter_pulse !== 1'b0) begin errors++; $display("FAIL n2_strobe letter=%0d strobe=%b hit=%b enter=%b exp %b %b 0", l, guess_strobe, guess_hit, enter_pulse, exp_g, exp_h); end
        checks++;
        if (used_mask !== m_used) begin errors++; $display("FAIL used_mask letter=%0d got=%h exp=%h", l, used_mask, m_used); end
        checks++;
        if (reveal_mask !== m_reveal()) begin errors++; $display("FAIL reveal_mask letter=%0d got=%b exp=%b", l, reveal_mask, m_reveal()); end
        checks++;
        if (int'(wrong_count) !== m_wrong()) begin errors++; $display("FAIL wrong_count letter=%0d got=%0d exp=%0d", l, wrong_count, m_wrong()); end
        checks++;
        if (game_won !== m_won() || game_lost !== m_lost()) begin errors++; $display("FAIL outcome letter=%0d won=%b lost=%b exp %b %b", l, game_won, game_lost, m_won(), m_lost()); end
        for (int i = 2; i < hold; i++) begin
            @(negedge clk);
            inputLetter = 5'($urandom_range(0, 27));
            strobes += int'(guess_strobe);
            checks++;
            if (guess_strobe !== 1'b0 || enter_pulse !== 1'b0) begin errors++; $display("FAIL held_quiet cycle=%0d strobe=%b enter=%b exp 0", i, guess_strobe, enter_pulse); end
        end
        @(negedge clk);
        pressed = 0; inputLetter = 5'($urandom_range(0, 27));
        @(negedge clk);
    endtask

    int cat[8] = '{2, 0, 19, 7, 7, 7, 7, 7};

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1;
        m_active = 0; m_used = '0;
        @(negedge clk);
        checks++;
        if ({guess_strobe, guess_hit, enter_pulse, used_mask, reveal_mask, wrong_count, game_won, game_lost} !== '0)
            begin errors++; $display("FAIL reset_outputs used=%h reveal=%b wrong=%0d exp all 0", used_mask, reveal_mask, wrong_count); end
    endtask

    task automatic test_cat_win();
        int s;
        load(cat, 3, 0);
        checks++;
        if (reveal_mask !== 8'b1111_1000) begin errors++; $display("FAIL cat_load_reveal got=%b exp=11111000", reveal_mask); end
        press(5'd0, 3, s);
        checks++;
        if (reveal_mask !== 8'b1111_1010 || used_mask[0] !== 1'b1) begin errors++; $display("FAIL cat_after_a reveal=%b used0=%b exp 11111010 1", reveal_mask, used_mask[0]); end
        press(5'd2, 2, s);
        press(5'd19, 2, s);
        checks++;
        if (game_won !== 1'b1 || game_lost !== 1'b0) begin errors++; $display("FAIL cat_won won=%b lost=%b exp 1 0", game_won, game_lost); end
        press(5'd1, 3, s);
        checks++;
        if (s !== 0) begin errors++; $display("FAIL done_ignores_letter strobes=%0d exp 0", s); end
        press(5'd26, 2, s);
    endtask

    task automatic test_repeat_and_loss();
        int s;
        int miss[6] = '{1, 3, 4, 5, 6, 7};
        load(cat, 3, 0);
        repeat (6) press(5'd25, 2, s);
        checks++;
        if (wrong_count !== 3'd1) begin errors++; $display("FAIL z_repeat wrong=%0d exp 1", wrong_count); end
        load(cat, 3, 0);
        foreach (miss[i]) press(5'(miss[i]), 2, s);
        checks++;
        if (wrong_count !== 3'd6 || game_lost !== 1'b1 || game_won !== 1'b0) begin errors++; $display("FAIL six_misses wrong=%0d lost=%b won=%b exp 6 1 0", wrong_count, game_lost, game_won); end
        press(5'd0, 2, s);
    endtask

    task automatic test_hold();
        int s;
        load(cat, 3, 0);
        press(5'd0, 50, s);
        checks++;
        if (s !== 1) begin errors++; $display("FAIL hold_one_strobe strobes=%0d exp 1", s); end
    endtask

    task automatic test_enter_none();
        int s;
        load(cat, 3, 0);
        press(5'd26, 2, s);
        press(5'd27, 2, s);
        press(5'd30, 2, s);
    endtask

    task automatic test_len0_and_coincident();
        int s;
        load(cat, 0, 0);
        checks++;
        if ({used_mask, reveal_mask, wrong_count, game_won, game_lost, guess_strobe} !== '0) begin errors++; $display("FAIL len0_idle reveal=%b used=%h exp 0", reveal_mask, used_mask); end
        press(5'd0, 2, s);
        load(cat, 3, 0);
        load(cat, 3, 1);
        press(5'd2, 2, s);
    endtask

    task automatic test_reset_in_check();
        load(cat, 3, 0);
        @(negedge clk);
        pressed = 1; inputLetter = 5'd0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1; pressed = 0;
        m_active = 0; m_used = '0;
        checks++;
        if ({guess_strobe, guess_hit, enter_pulse, used_mask, reveal_mask, wrong_count, game_won, game_lost} !== '0)
            begin errors++; $display("FAIL reset_in_check strobe=%b used=%h reveal=%b exp all 0", guess_strobe, used_mask, reveal_mask); end
        @(negedge clk);
        checks++;
        if (guess_strobe !== 1'b0 || used_mask !== 26'd0) begin errors++; $display("FAIL reset_discard strobe=%b used=%h exp 0", guess_strobe, used_mask); end
    endtask

    task automatic test_random();
        int s, w[8], r;
        logic [4:0] l;
        for (int g = 0; g < 10; g++) begin
            for (int i = 0; i < 8; i++) w[i] = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 11) : $urandom_range(26, 31);
            w[0] = $urandom_range(0, 11);
            load(w, $urandom_range(1, 15), $urandom_range(0, 3) == 0);
            for (int p = 0; p < 20; p++) begin
                r = $urandom_range(0, 19);
                l = (r == 18) ? 5'd26 : (r == 19) ? 5'd27 : 5'($urandom_range(0, 13));
                press(l, $urandom_range(2, 4), s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cat_win();
        test_repeat_and_loss();
        test_hold();
        test_enter_none();
        test_len0_and_coincident();
        test_reset_in_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
